// File: rtl/spi_pkg.sv
// Shared definitions for the SPI clock sequencer and the shift stage it feeds.
package spi_pkg;

    localparam int DIV_W_DEF         = 16;
    localparam int DLY_W_DEF         = 8;
    localparam int SPI_CHAR_LEN_BITS = 5;
    localparam int SPI_MAX_CHAR      = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LEAD  = 2'd1,
        RUN   = 2'd2,
        TRAIL = 2'd3
    } seq_state_e;

endpackage

// File: rtl/spi_clk_seq_if.sv
// Control and timing signals between the transfer controller / shift stage and the clock sequencer.
interface spi_clk_seq_if #(
    parameter int DIV_W = spi_pkg::DIV_W_DEF,
    parameter int DLY_W = spi_pkg::DLY_W_DEF
);
    logic             go;
    logic             abort;
    logic [DIV_W-1:0] divider;
    logic [DLY_W-1:0] lead_dly;
    logic [DLY_W-1:0] trail_dly;
    logic             cpol;
    logic             last;
    logic             s_clk;
    logic             sclk_pad;
    logic             pos_edge;
    logic             neg_edge;
    logic             ss_n;
    logic             busy;
    logic             done;

    modport master (
        output go, abort, divider, lead_dly, trail_dly, cpol, last,
        input  s_clk, sclk_pad, pos_edge, neg_edge, ss_n, busy, done
    );

    modport slave (
        input  go, abort, divider, lead_dly, trail_dly, cpol, last,
        output s_clk, sclk_pad, pos_edge, neg_edge, ss_n, busy, done
    );
endinterface

// File: rtl/spi_tick_div.sv
// Reloadable half-period down-counter; tick is high whenever the count has reached zero.
module spi_tick_div #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic [W-1:0] reload_val,
    output logic         tick
);
    logic [W-1:0] cnt_r;

    // Explicit load wins, otherwise reload on tick, otherwise count down
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= {W{1'b0}};
        end else if (load) begin
            cnt_r <= load_val;
        end else if (cnt_r == {W{1'b0}}) begin
            cnt_r <= reload_val;
        end else begin
            cnt_r <= cnt_r - W'(1);
        end
    end

    assign tick = (cnt_r == {W{1'b0}});
endmodule

// File: rtl/spi_clk_seq.sv
// Transfer timing sequencer: turns go into ss_n framing, serial clock and edge strobes for the shift stage.
module spi_clk_seq #(
    parameter int DIV_W = spi_pkg::DIV_W_DEF,
    parameter int DLY_W = spi_pkg::DLY_W_DEF
) (
    input  logic         clk_shift,
    input  logic         rst_n,
    spi_clk_seq_if.slave bus
);
    import spi_pkg::*;

    seq_state_e       state_r;
    logic [DIV_W-1:0] div_cfg_r;
    logic [DLY_W-1:0] lead_cfg_r;
    logic [DLY_W-1:0] trail_cfg_r;
    logic [DLY_W-1:0] dly_cnt_r;
    logic             cpol_cfg_r;
    logic             s_clk_r;
    logic             pos_edge_r;
    logic             neg_edge_r;
    logic             ss_n_r;
    logic             busy_r;
    logic             done_r;

    logic             accept_s;
    logic             abort_s;
    logic             load_s;
    logic             tick_s;
    logic             step_s;
    logic             term_s;
    logic [DIV_W-1:0] load_val_s;

    // A go seen while done is high is refused so a held request restarts one cycle later
    assign accept_s   = (state_r == IDLE) && bus.go && !done_r;
    assign abort_s    = bus.abort && ((state_r == LEAD) || (state_r == RUN));
    assign load_s     = accept_s || abort_s;
    assign load_val_s = accept_s ? bus.divider : div_cfg_r;
    // The tick that ends LEAD also produces the first serial clock edge
    assign step_s     = tick_s && ((state_r == RUN) ||
                                   ((state_r == LEAD) && (dly_cnt_r == lead_cfg_r)));
    assign term_s     = bus.last && !s_clk_r;

    spi_tick_div #(.W(DIV_W)) u_tick_div (
        .clk        (clk_shift),
        .rst_n      (rst_n),
        .load       (load_s),
        .load_val   (load_val_s),
        .reload_val (div_cfg_r),
        .tick       (tick_s)
    );

    // Sequencer state, configuration latches and registered strobes
    always_ff @(posedge clk_shift or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            div_cfg_r   <= {DIV_W{1'b0}};
            lead_cfg_r  <= {DLY_W{1'b0}};
            trail_cfg_r <= {DLY_W{1'b0}};
            dly_cnt_r   <= {DLY_W{1'b0}};
            cpol_cfg_r  <= 1'b0;
            s_clk_r     <= 1'b0;
            pos_edge_r  <= 1'b0;
            neg_edge_r  <= 1'b0;
            ss_n_r      <= 1'b1;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            pos_edge_r <= 1'b0;
            neg_edge_r <= 1'b0;
            done_r     <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        div_cfg_r   <= bus.divider;
                        lead_cfg_r  <= bus.lead_dly;
                        trail_cfg_r <= bus.trail_dly;
                        cpol_cfg_r  <= bus.cpol;
                        dly_cnt_r   <= {DLY_W{1'b0}};
                        ss_n_r      <= 1'b0;
                        busy_r      <= 1'b1;
                        state_r     <= LEAD;
                    end
                end
                LEAD, RUN: begin
                    if (abort_s) begin
                        s_clk_r   <= 1'b0;
                        dly_cnt_r <= {DLY_W{1'b0}};
                        state_r   <= TRAIL;
                    end else if (step_s && term_s) begin
                        pos_edge_r <= 1'b1;
                        dly_cnt_r  <= {DLY_W{1'b0}};
                        state_r    <= TRAIL;
                    end else if (step_s) begin
                        s_clk_r    <= ~s_clk_r;
                        pos_edge_r <= ~s_clk_r;
                        neg_edge_r <= s_clk_r;
                        state_r    <= RUN;
                    end else if (tick_s) begin
                        dly_cnt_r <= dly_cnt_r + DLY_W'(1);
                    end
                end
                TRAIL: begin
                    if (tick_s && (dly_cnt_r == trail_cfg_r)) begin
                        ss_n_r  <= 1'b1;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                        state_r <= IDLE;
                    end else if (tick_s) begin
                        dly_cnt_r <= dly_cnt_r + DLY_W'(1);
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign bus.s_clk    = s_clk_r;
    assign bus.sclk_pad = s_clk_r ^ cpol_cfg_r;
    assign bus.pos_edge = pos_edge_r;
    assign bus.neg_edge = neg_edge_r;
    assign bus.ss_n     = ss_n_r;
    assign bus.busy     = busy_r;
    assign bus.done     = done_r;
endmodule

// File: tb/tb_spi_clk_seq.sv
// Self-checking bench for spi_clk_seq: per-cycle comparison against an arithmetic timing model.
module tb_spi_clk_seq;
    import spi_pkg::*;

    localparam int DW = DIV_W_DEF;
    localparam int LW = DLY_W_DEF;

    logic clk;
    logic rst_n;
    int   cyc     = 0;
    int   n_cmp   = 0;
    int   n_bad   = 0;
    int   stub_n  = 1;
    int   neg_cnt = 0;
    logic [6:0] rst_v;

    spi_clk_seq_if #(.DIV_W(DW), .DLY_W(LW)) sif ();

    spi_clk_seq #(.DIV_W(DW), .DLY_W(LW)) dut (
        .clk_shift (clk),
        .rst_n     (rst_n),
        .bus       (sif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Shift-stage stub: last rises once stub_n falling edges have been delivered
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)           neg_cnt <= 0;
        else if (sif.ss_n)    neg_cnt <= 0;
        else if (sif.neg_edge) neg_cnt <= neg_cnt + 1;
    end
    assign sif.last = ((neg_cnt + (sif.neg_edge ? 1 : 0)) == stub_n);

    function automatic logic [6:0] dut_out();
        return {sif.s_clk, sif.sclk_pad, sif.pos_edge, sif.neg_edge, sif.ss_n, sif.busy, sif.done};
    endfunction

    // Expected outputs c cycles after the go-accepting edge; half period h, abort edge ab (0 = none)
    function automatic logic [6:0] ref_out(int c, int h, int ld, int tr, int n, int ab, int cp);
        int first, span, fin, off;
        logic sc, pe, ne, cb;
        first = (ld + 1) * h;
        span  = 2 * n * h;
        fin   = ((ab > 0) ? ab : first + span) + (tr + 1) * h;
        off   = c - first;
        cb    = (cp != 0);
        sc = 1'b0; pe = 1'b0; ne = 1'b0;
        if ((ab == 0 || c < ab) && off >= 0 && off <= span) begin
            sc = (off < span) && ((off / h) % 2 == 0);
            pe = (off % h == 0) && ((off / h) % 2 == 0);
            ne = (off % h == 0) && ((off / h) % 2 == 1);
        end
        return {sc, sc ^ cb, pe, ne, !(c < fin), (c < fin), (c == fin)};
    endfunction

    // Runs one transfer from the current negedge and checks every cycle until two cycles past done
    task automatic run_xfer(input int dv, input int ld, input int tr, input int cp, input int n,
                            input int ab, input int chg, input string tag);
        int h, term, fin, tstart;
        logic [6:0] exp_v, act_v;
        sif.divider   = DW'(dv);
        sif.lead_dly  = LW'(ld);
        sif.trail_dly = LW'(tr);
        sif.cpol      = (cp != 0);
        sif.abort     = 1'b0;
        stub_n        = n;
        sif.go        = 1'b1;
        @(negedge clk);
        h      = dv + 1;
        term   = (ld + 1 + 2 * n) * h;
        tstart = (ab > 0) ? ab : term;
        fin    = tstart + (tr + 1) * h;
        sif.go        = 1'b0;
        sif.divider   = (chg >= 0) ? DW'(chg) : DW'($urandom);
        sif.lead_dly  = LW'($urandom);
        sif.trail_dly = LW'($urandom);
        sif.cpol      = 1'($urandom_range(0, 1));
        for (int c = 0; c <= fin + 2; c++) begin
            exp_v = ref_out(c, h, ld, tr, n, ab, cp);
            act_v = dut_out();
            n_cmp++;
            if (act_v !== exp_v) begin
                n_bad++;
                $display("FAIL %s c=%0d {sclk,pad,pos,neg,ss_n,busy,done} actual=%b required=%b",
                         tag, c, act_v, exp_v);
            end
            sif.go    = (c <= fin) ? 1'($urandom_range(0, 1)) : 1'b0;
            sif.abort = ((ab > 0) && (c == ab - 1)) || ((c >= tstart) && ($urandom_range(0, 1) == 1));
            if (c < fin + 2) @(negedge clk);
        end
        sif.go    = 1'b0;
        sif.abort = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_cmp++;
        if (dut_out() !== rst_v) begin
            n_bad++;
            $display("FAIL reset_state actual=%b required=%b", dut_out(), rst_v);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (dut_out() !== rst_v) begin
            n_bad++;
            $display("FAIL idle_after_reset actual=%b required=%b", dut_out(), rst_v);
        end
    endtask

    task automatic test_basic();
        run_xfer(1, 0, 0, 0, 8, 0, -1, "basic_div1");
    endtask

    task automatic test_fast_delays();
        run_xfer(0, 3, 2, 0, 5, 0, -1, "div0_lead3_trail2");
    endtask

    task automatic test_cpol();
        run_xfer(2, 1, 1, 1, 4, 0, -1, "cpol1_div2");
        run_xfer(2, 1, 1, 0, 4, 0, -1, "cpol0_div2");
    endtask

    task automatic test_div_change();
        run_xfer(1, 1, 0, 0, 6, 0, 7, "div_change_mid");
        run_xfer(7, 0, 0, 0, 2, 0, -1, "div7_next_go");
    endtask

    task automatic test_abort();
        run_xfer(2, 1, 2, 0, 8, 8, -1, "abort_sclk_high");
        run_xfer(1, 2, 1, 0, 4, 3, -1, "abort_in_lead");
    endtask

    // go held high: refused in the done cycle, accepted on the next one
    task automatic test_back_to_back();
        int fin;
        logic [6:0] exp_v;
        sif.divider = DW'(1); sif.lead_dly = LW'(1); sif.trail_dly = LW'(1); sif.cpol = 1'b0;
        stub_n = 3;
        sif.go = 1'b1;
        @(negedge clk);
        fin = (2 + 6) * 2 + 2 * 2;
        for (int c = 0; c <= 2 * fin + 4; c++) begin
            exp_v = (c < fin + 2) ? ref_out(c, 2, 1, 1, 3, 0, 0) : ref_out(c - fin - 2, 2, 1, 1, 3, 0, 0);
            n_cmp++;
            if (dut_out() !== exp_v) begin
                n_bad++;
                $display("FAIL back_to_back c=%0d actual=%b required=%b", c, dut_out(), exp_v);
            end
            sif.go = (c <= fin + 1);
            if (c < 2 * fin + 4) @(negedge clk);
        end
        sif.go = 1'b0;
    endtask

    task automatic test_async_reset();
        logic [6:0] exp_v;
        sif.divider = DW'(3); sif.lead_dly = LW'(0); sif.trail_dly = LW'(0); sif.cpol = 1'b0;
        stub_n = 8;
        sif.go = 1'b1;
        @(negedge clk);
        sif.go = 1'b0;
        repeat (5) @(negedge clk);
        exp_v = ref_out(5, 4, 0, 0, 8, 0, 0);
        n_cmp++;
        if (dut_out() !== exp_v) begin
            n_bad++;
            $display("FAIL pre_reset_run actual=%b required=%b", dut_out(), exp_v);
        end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (dut_out() !== rst_v) begin
            n_bad++;
            $display("FAIL async_reset actual=%b required=%b", dut_out(), rst_v);
        end
        repeat (2) @(negedge clk);
        n_cmp++;
        if (dut_out() !== rst_v) begin
            n_bad++;
            $display("FAIL reset_hold actual=%b required=%b", dut_out(), rst_v);
        end
        rst_n = 1'b1;
        @(negedge clk);
        run_xfer(0, 1, 1, 0, 3, 0, -1, "post_reset");
    endtask

    task automatic test_random();
        for (int i = 0; i < 10; i++) begin
            int dv, ld, tr, cp, n, ab;
            dv = $urandom_range(0, 3);
            ld = $urandom_range(0, 3);
            tr = $urandom_range(0, 3);
            cp = $urandom_range(0, 1);
            n  = $urandom_range(1, 8);
            ab = 0;
            if ($urandom_range(0, 3) == 0) ab = $urandom_range(1, (ld + 1 + 2 * n) * (dv + 1));
            run_xfer(dv, ld, tr, cp, n, ab, -1, "random");
        end
    endtask

    initial begin
        rst_v         = 7'b0000100;
        rst_n         = 1'b0;
        sif.go        = 1'b0;
        sif.abort     = 1'b0;
        sif.divider   = DW'(0);
        sif.lead_dly  = LW'(0);
        sif.trail_dly = LW'(0);
        sif.cpol      = 1'b0;
        test_reset();
        test_basic();
        test_fast_delays();
        test_cpol();
        test_div_change();
        test_abort();
        test_back_to_back();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/spi_clk_seq.md
Name: spi_clk_seq

Overview:
- Transfer timing sequencer directly upstream of the SPI shift register.
- Turns a `go` request into the serial-clock pulse stream that the shift stage consumes: s_clk, single-cycle pos_edge/neg_edge strobes, and a final tip-retiring strobe.
- Also drives an active-low slave select with programmable lead and trail delays.
- Stops clocking when the shift stage reports `last`.

Parameters:
- DIV_W, 16, width of the half-period divider.
- DLY_W, 8, width of the lead/trail delay fields.

Ports:
- clk_shift  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- go  in  1  start request; accepted only in IDLE.
- abort  in  1  terminate the current transfer early.
- divider  in  DIV_W  half period = divider+1 clk_shift cycles.
- lead_dly  in  DLY_W  half periods from ss_n falling to the first s_clk edge, minus one.
- trail_dly  in  DLY_W  half periods from the end of clocking to ss_n rising, minus one.
- cpol  in  1  idle level of sclk_pad.
- last  in  1  last-bit flag from the shift stage.
- s_clk  out  1  internal serial clock; idle 0; feeds the shift stage.
- sclk_pad  out  1  s_clk XOR cpol_q, to the pin.
- pos_edge  out  1  one-cycle strobe.
- neg_edge  out  1  one-cycle strobe.
- ss_n  out  1  slave select, active-low.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse on return to IDLE.

Behaviour:
- Reset values: state=IDLE, s_clk=0, pos_edge=0, neg_edge=0, ss_n=1, done=0, div counter=0, delay counter=0, config latches=0. Reset is asynchronous and may occur in any state, including mid-transfer; outputs return to these values immediately.
- Config latch: divider, lead_dly, trail_dly and cpol are latched on the cycle go is accepted. Later changes to these inputs have no effect until the next accepted go.
- Tick generation:
  - The div counter loads divider_q on every state entry.
  - It decrements once per cycle.
  - tick = (counter==0); on a tick the counter reloads divider_q.
  - With divider=0, a tick occurs every cycle.
- States: IDLE, LEAD, RUN, TRAIL.
- IDLE:
  - On go: latch config, ss_n<=0, move to LEAD.
  - go while busy is ignored.
- LEAD:
  - Waits lead_dly_q+1 ticks, then moves to RUN.
  - s_clk stays 0; no strobes.
- RUN, on each tick:
  - If last==1 and s_clk==0: pos_edge<=1 for one cycle with s_clk held 0 (terminal strobe, which retires tip in the shift stage), then move to TRAIL.
  - Otherwise: s_clk<=~s_clk, pos_edge<=~s_clk_old, neg_edge<=s_clk_old.
  - Every strobe is registered and coincides with the first cycle of the new s_clk level.
- TRAIL:
  - Waits trail_dly_q+1 ticks, then ss_n<=1, done<=1 for one cycle, move to IDLE.
- abort in LEAD or RUN:
  - Next cycle s_clk<=0 with no strobes; move to TRAIL.
  - abort in TRAIL or IDLE is ignored.
- Simultaneous events:
  - abort has priority over a tick in the same cycle.
  - A go arriving in the cycle done is asserted is ignored; a new go is accepted from the next cycle.
- Edge-count contract: for a shift stage with count N, RUN produces exactly N rising edges, N falling edges and 1 terminal strobe, i.e. N+1 pos_edge and N neg_edge pulses.
- pos_edge and neg_edge are never high in the same cycle.
- sclk_pad is combinational s_clk XOR cpol_q; it is glitch-free because both operands are registers.

Decomposition:
- Shared package spi_pkg holds:
  - state enum type (IDLE, LEAD, RUN, TRAIL);
  - DIV_W and DLY_W defaults;
  - SPI_CHAR_LEN_BITS=5 and SPI_MAX_CHAR=32 constants, shared with the shift stage.
- One sub-module: spi_tick_div, the reloadable down-counter producing tick, with a load input driven on state entry.

Test Plan:
1. divider=1, lead=0, trail=0, last modelled by 8-count shift stub; go -> ss_n falls 1 cycle after go; s_clk period 4 cycles; 9 pos_edge, 8 neg_edge pulses; ss_n rises 2 cycles after the terminal strobe; done pulses once.
2. divider=0, lead=3, trail=2 -> 4 cycles from ss_n low to first s_clk rise; 3 cycles from terminal strobe to ss_n high; a strobe every cycle during RUN.
3. cpol=1 with divider=2 -> sclk_pad idles 1 and toggles inverted from s_clk; s_clk still idles 0; strobe timing identical to cpol=0.
4. Change divider from 1 to 7 mid-RUN -> period stays 4 cycles until done; the next go uses a 16-cycle period.
5. abort while s_clk=1 in RUN -> s_clk=0 next cycle with no neg_edge; TRAIL timing as programmed; done pulses.
6. rst_n low mid-RUN -> s_clk=0, ss_n=1, busy=0 asynchronously; go 2 cycles after reset release starts a normal transfer.
